// File: rtl/ntt_pkg.sv
// ntt_pkg -- shared constants and types for the Kyber NTT sequencer.
//   KYBER_N / KYBER_Q : polynomial size and modulus
//   NTT_LAYERS        : butterfly layers in one transform (log2(N)-1)
//   BFU_LAT           : default butterfly-unit pipeline depth
//   ntt_state_t       : sequencer FSM states
//   coef_addr_t       : coefficient RAM address (8 bits)
//   tw_addr_t         : twiddle ROM index (7 bits)
package ntt_pkg;
  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int NTT_LAYERS = 7;
  localparam int BFU_LAT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_t;

  typedef logic [7:0] coef_addr_t;
  typedef logic [6:0] tw_addr_t;
endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen -- combinational butterfly address / twiddle generator.
// Ports:
//   i_layer   : layer 0..6
//   i_idx     : butterfly index within the layer, 0..127
//   i_intt    : 0 = forward NTT, 1 = inverse NTT
//   o_addr_a  : coefficient address of operand a
//   o_addr_b  : coefficient address of operand b (a + len)
//   o_tw_addr : twiddle ROM index
// The span len is always a power of two, so every divide/modulo below is a
// shift or a mask; lg = log2(len) is 1..7.
import ntt_pkg::*;

module ntt_addr_gen (
  input  logic [2:0] i_layer,
  input  logic [6:0] i_idx,
  input  logic       i_intt,
  output coef_addr_t o_addr_a,
  output coef_addr_t o_addr_b,
  output tw_addr_t   o_tw_addr
);

  logic [2:0] w_lg;
  logic [7:0] w_len;
  logic [6:0] w_mask;
  logic [6:0] w_g;
  logic [6:0] w_o;
  logic [7:0] w_base;
  logic [6:0] w_tw_ntt;
  logic [6:0] w_tw_intt;

  // NTT spans shrink 128..2, INTT spans grow 2..128.
  assign w_lg   = i_intt ? (i_layer + 3'd1) : (3'd7 - i_layer);
  assign w_len  = 8'd1 << w_lg;
  assign w_mask = w_len[6:0] - 7'd1;
  assign w_g    = i_idx >> w_lg;
  assign w_o    = i_idx & w_mask;
  // Group base is 2*len*g; for lg=7 the group index is always 0.
  assign w_base = {1'b0, w_g} << ({1'b0, w_lg} + 4'd1);

  assign o_addr_a = w_base | {1'b0, w_o};
  assign o_addr_b = o_addr_a + w_len;

  // 128/len == 64 >> (lg-1);  256/len - 1 == 127 >> (lg-1).
  assign w_tw_ntt  = (7'd64 >> (w_lg - 3'd1)) + w_g;
  assign w_tw_intt = (7'h7F >> (w_lg - 3'd1)) - w_g;
  assign o_tw_addr = i_intt ? w_tw_intt : w_tw_ntt;

endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl -- sequences one 256-point Kyber NTT / INTT through a single BFU.
// Optional build macro: NTT_CTRL_PERF_EN adds a 16-bit busy-cycle counter.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_start, i_intt         : start request and mode (sampled in IDLE)
//   o_busy, o_done          : run in progress / one-cycle completion pulse
//   o_bfu_intt              : BFU mode, latched at start
//   o_rd_en, o_rd_addr_a/b  : coefficient RAM read strobe and addresses
//   o_tw_addr               : twiddle ROM index
//   o_wr_en, o_wr_addr_a/b  : write-back strobe and addresses (read delayed D)
//   o_cycle_cnt             : busy-cycle count (NTT_CTRL_PERF_EN only)
// All outputs are registered; the address generator is fed with next-state
// values so the read address is aligned with o_rd_en.
import ntt_pkg::*;

module ntt_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int BFU_LAT = ntt_pkg::BFU_LAT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_intt,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_bfu_intt,
  output logic       o_rd_en,
  output logic [7:0] o_rd_addr_a,
  output logic [7:0] o_rd_addr_b,
  output logic [6:0] o_tw_addr,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr_a,
  output logic [7:0] o_wr_addr_b
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [15:0] o_cycle_cnt
`endif
);

  localparam int D = RD_LAT + BFU_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(D - 1);
  localparam logic [2:0] LAST_LAYER = 3'(NTT_LAYERS - 1);
  localparam logic [6:0] LAST_IDX = 7'(KYBER_N / 2 - 1);

  ntt_state_t r_state, w_state_nxt;
  logic [2:0]    r_layer, w_layer_nxt;
  logic [6:0]    r_idx, w_idx_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic          r_intt, w_intt_nxt;

  coef_addr_t w_gen_a, w_gen_b;
  tw_addr_t   w_gen_tw;

  logic       r_rd_en, r_busy, r_done;
  coef_addr_t r_rd_addr_a, r_rd_addr_b;
  tw_addr_t   r_tw_addr;

  logic       r_wr_en_dl [D];
  coef_addr_t r_wr_a_dl  [D];
  coef_addr_t r_wr_b_dl  [D];

  ntt_addr_gen u_addr_gen (
    .i_layer   (w_layer_nxt),
    .i_idx     (w_idx_nxt),
    .i_intt    (w_intt_nxt),
    .o_addr_a  (w_gen_a),
    .o_addr_b  (w_gen_b),
    .o_tw_addr (w_gen_tw)
  );

  // FSM state and loop counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_layer <= 3'd0;
      r_idx   <= 7'd0;
      r_drain <= '0;
      r_intt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_idx   <= w_idx_nxt;
      r_drain <= w_drain_nxt;
      r_intt  <= w_intt_nxt;
    end
  end

  // Next-state logic: 128 issues, D drain cycles, per layer.
  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_idx_nxt   = r_idx;
    w_drain_nxt = r_drain;
    w_intt_nxt  = r_intt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_intt_nxt  = i_intt;
          w_layer_nxt = 3'd0;
          w_idx_nxt   = 7'd0;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_idx == LAST_IDX) begin
          w_drain_nxt = '0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_idx_nxt = r_idx + 7'd1;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          if (r_layer == LAST_LAYER) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_layer_nxt = r_layer + 3'd1;
            w_idx_nxt   = 7'd0;
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      ST_DONE: begin
        // A start in this cycle is deliberately dropped.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered read-side outputs; addresses hold outside ISSUE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_addr   <= '0;
    end else begin
      r_rd_en <= (w_state_nxt == ST_ISSUE);
      r_busy  <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_state_nxt == ST_ISSUE) begin
        r_rd_addr_a <= w_gen_a;
        r_rd_addr_b <= w_gen_b;
        r_tw_addr   <= w_gen_tw;
      end
    end
  end

  // Write-back delay line: read strobe/addresses delayed exactly D cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < D; k++) begin
        r_wr_en_dl[k] <= 1'b0;
        r_wr_a_dl[k]  <= '0;
        r_wr_b_dl[k]  <= '0;
      end
    end else begin
      r_wr_en_dl[0] <= r_rd_en;
      r_wr_a_dl[0]  <= r_rd_addr_a;
      r_wr_b_dl[0]  <= r_rd_addr_b;
      for (int k = 1; k < D; k++) begin
        r_wr_en_dl[k] <= r_wr_en_dl[k-1];
        r_wr_a_dl[k]  <= r_wr_a_dl[k-1];
        r_wr_b_dl[k]  <= r_wr_b_dl[k-1];
      end
    end
  end

`ifdef NTT_CTRL_PERF_EN
  logic [15:0] r_cycle_cnt;

  // Busy-cycle counter; frozen once the run leaves DRAIN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= 16'd0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_cycle_cnt <= 16'd0;
    end else if ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_bfu_intt  = r_intt;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr_a = r_rd_addr_a;
  assign o_rd_addr_b = r_rd_addr_b;
  assign o_tw_addr   = r_tw_addr;
  assign o_wr_en     = r_wr_en_dl[D-1];
  assign o_wr_addr_a = r_wr_a_dl[D-1];
  assign o_wr_addr_b = r_wr_b_dl[D-1];

endmodule
